// File: rtl/proc_clock_ctrl_if.sv
// Signal bundle between the processor clock controller and its board/processor side.
// master = board/processor side that drives the controls; slave = the controller.
interface proc_clock_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             clk_1Hz;
  logic             key_step;
  logic [1:0]       sw_mode;
  logic             halt_req;
  logic             cpu_en;
  logic             running;
  logic             stopped;
  logic [CNT_W-1:0] step_count;
  logic [2:0]       dbg_state;

  // cpu_en is a one-cycle strobe with no backpressure: the processor must take a
  // step on every clk_50MHz cycle where it is high. dbg_state encodes the FSM as
  // 0 IDLE, 1 STEP, 2 SLOW_RUN, 3 FAST_RUN, 4 CPU_STOP.
  modport master (
    output clk_1Hz, key_step, sw_mode, halt_req,
    input  cpu_en, running, stopped, step_count, dbg_state
  );

  modport slave (
    input  clk_1Hz, key_step, sw_mode, halt_req,
    output cpu_en, running, stopped, step_count, dbg_state
  );
endinterface

// File: rtl/proc_clock_ctrl.sv
// Processor step-enable generator: halt / single-step / 1 Hz / full-speed modes.
// Optional `STEP_COUNTER_EN` adds the cpu_en pulse counter on step_count.
module proc_clock_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 16
) (
  input  logic                clk_50MHz,
  input  logic                reset,
  proc_clock_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STEP     = 3'd1,
    SLOW_RUN = 3'd2,
    FAST_RUN = 3'd3,
    CPU_STOP = 3'd4
  } state_e;

  localparam int            DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            hz_s1_q, hz_s2_q, hz_s3_q;
  logic            key_s1_q, key_s2_q;
  logic            key_db_q, key_db_d;
  logic            key_db_prev_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]      mode_s1_q, mode_s2_q;
  state_e          state_q, state_d;
  logic            cpu_en_q, cpu_en_d;
  logic            running_q, running_d;
  logic            stopped_q, stopped_d;
  logic            tick;
  logic            press;

  // Synchronizers, debouncer and edge register.
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      hz_s1_q       <= 1'b0;
      hz_s2_q       <= 1'b0;
      hz_s3_q       <= 1'b0;
      key_s1_q      <= 1'b0;
      key_s2_q      <= 1'b0;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      mode_s1_q     <= 2'b00;
      mode_s2_q     <= 2'b00;
    end else begin
      hz_s1_q       <= bus.clk_1Hz;
      hz_s2_q       <= hz_s1_q;
      hz_s3_q       <= hz_s2_q;
      key_s1_q      <= bus.key_step;
      key_s2_q      <= key_s1_q;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      db_cnt_q      <= db_cnt_d;
      mode_s1_q     <= bus.sw_mode;
      mode_s2_q     <= mode_s1_q;
    end
  end

  // The debounced key only moves after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (key_s2_q != key_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        key_db_d = key_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign tick  = hz_s2_q & ~hz_s3_q;
  assign press = key_db_prev_q & ~key_db_q;

  function automatic state_e mode_state(input logic [1:0] m);
    case (m)
      2'b01:   return STEP;
      2'b10:   return SLOW_RUN;
      2'b11:   return FAST_RUN;
      default: return IDLE;
    endcase
  endfunction

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cpu_en_q  <= 1'b0;
      running_q <= 1'b0;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      running_q <= running_d;
      stopped_q <= stopped_d;
    end
  end

  // A mode change always wins over a same-cycle press or tick, so those are dropped.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    if (state_q != IDLE && mode_s2_q == 2'b00) begin
      state_d = IDLE;
    end else if (bus.halt_req &&
                 (state_q == STEP || state_q == SLOW_RUN || state_q == FAST_RUN)) begin
      state_d = CPU_STOP;
    end else begin
      case (state_q)
        IDLE: state_d = mode_state(mode_s2_q);
        STEP: begin
          if (mode_s2_q != 2'b01) state_d = mode_state(mode_s2_q);
          else                    cpu_en_d = press;
        end
        SLOW_RUN: begin
          if (mode_s2_q != 2'b10) state_d = mode_state(mode_s2_q);
          else                    cpu_en_d = tick;
        end
        FAST_RUN: begin
          if (mode_s2_q != 2'b11) state_d = mode_state(mode_s2_q);
          else                    cpu_en_d = 1'b1;
        end
        CPU_STOP: state_d = CPU_STOP;
        default:  state_d = IDLE;
      endcase
    end
    running_d = (state_d == SLOW_RUN) || (state_d == FAST_RUN);
    stopped_d = (state_d == CPU_STOP);
  end

  assign bus.cpu_en    = cpu_en_q;
  assign bus.running   = running_q;
  assign bus.stopped   = stopped_q;
  assign bus.dbg_state = state_q;

`ifdef STEP_COUNTER_EN
  logic [CNT_W-1:0] step_cnt_q;

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      step_cnt_q <= '0;
    end else if (cpu_en_q) begin
      step_cnt_q <= step_cnt_q + CNT_W'(1);
    end
  end

  assign bus.step_count = step_cnt_q;
`else
  assign bus.step_count = '0;
`endif

endmodule

// File: doc/proc_clock_ctrl.md
Name: proc_clock_ctrl

Overview:
- Sits directly downstream of the 1 Hz slow-clock divider. Consumes its `clk_1Hz` square wave plus a board pushbutton and mode switches.
- Produces a single-cycle `cpu_en` pulse that advances the processor datapath by one step, all in the `clk_50MHz` domain.
- Supports four modes: halt, manual single-step, 1 Hz slow run and full-speed run. A processor-issued halt request stops execution.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable `clk_50MHz` cycles needed to accept a key level change (20 ms at 50 MHz).
- CNT_W, 16, width of `step_count`.

Ports:
- clk_50MHz  input  1  system clock, 50 MHz; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- clk_1Hz  input  1  slow square wave from the divider; treated as asynchronous and synchronized internally.
- key_step  input  1  raw pushbutton, active-low (pressed = 0).
- sw_mode  input  2  mode select: 00 halt, 01 single-step, 10 slow run, 11 fast run.
- halt_req  input  1  processor halt request (HLT executed); level, sampled each cycle.
- cpu_en  output  1  one-cycle step-enable pulse to the processor.
- running  output  1  high in SLOW_RUN or FAST_RUN; drives an LED.
- stopped  output  1  high in CPU_STOP state.
- step_count  output  CNT_W  number of `cpu_en` pulses issued since reset.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - State = IDLE.
  - `cpu_en`, `running`, `stopped` = 0; `step_count` = 0.
  - Synchronizers and edge register = 0; debounced key = 1 (released); debounce counter = 0.
- `clk_1Hz` path: 2-FF synchronizer (s1, s2) followed by a previous-value register s3.
  - tick = s2 & ~s3.
  - A `clk_1Hz` rising edge produces tick during the cycle after the 2nd `clk_50MHz` edge.
  - The corresponding `cpu_en` is high for exactly the one cycle after the 3rd edge.
- Key path: 2-FF synchronizer, then debounce.
  - Counter increments while the synced key differs from the debounced key and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 and the synced key still differs, the debounced key takes the new value and the counter clears.
  - press = registered 1→0 transition of the debounced key; it is a one-cycle pulse.
  - Releases generate nothing. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- sw_mode is passed through a 2-FF synchronizer before use.
- States and per-cycle transitions (priority top to bottom):
  - Any state except IDLE with synced `sw_mode` = 00 → IDLE.
  - Any run or step state with `halt_req` = 1 → CPU_STOP. The `cpu_en` pulse for that cycle is suppressed.
  - IDLE: `sw_mode` 01 → STEP; 10 → SLOW_RUN; 11 → FAST_RUN; 00 → stay.
  - STEP: press → `cpu_en` = 1 next cycle. A mode change goes directly to the new mode's state.
  - SLOW_RUN: tick → `cpu_en` = 1 next cycle. Mode change goes to the new mode's state.
  - FAST_RUN: `cpu_en` = 1 every cycle. Mode change goes to the new mode's state.
  - CPU_STOP: `cpu_en` = 0; stays until `sw_mode` = 00 (→ IDLE). `halt_req` deasserting alone does not leave CPU_STOP.
- `cpu_en` is registered, never wider than 1 cycle except in FAST_RUN, and is 0 in IDLE and CPU_STOP.
- Moving from FAST_RUN to any other state drops `cpu_en` on the first cycle of the new state.
- A press or tick arriving in the same cycle as a mode change is dropped.
- `running` and `stopped` are registered decodes of the next state.
- `step_count` increments by 1 on each cycle `cpu_en` = 1. It wraps from 2^CNT_W-1 to 0 and is not cleared by IDLE.
- Reset asserted mid-pulse clears `cpu_en` immediately, asynchronously.

Optional Feature:
- Macro: `STEP_COUNTER_EN`.
- Defined: `step_count` is implemented as specified above.
- Undefined: `step_count` is tied to 0, no counter flops are synthesized, and all other behaviour is unchanged.

Test Plan:
- Reset then `sw_mode` = 10 with DEBOUNCE_CYCLES = 4 and `clk_1Hz` toggling every 20 cycles → one `cpu_en` pulse per `clk_1Hz` rising edge, each 1 cycle wide, 3 edges after the input rises; `step_count` = 3 after 3 rising edges.
- `sw_mode` = 01, `key_step` low for 10 cycles → exactly one `cpu_en`, 1 cycle after the debounced key falls (key + 2 sync + 4 debounce); a 2-cycle low glitch → no pulse.
- `sw_mode` = 11 for 8 cycles after the state is entered, then 00 → 8 consecutive `cpu_en` cycles, then 0; `running` 1→0; state IDLE.
- `sw_mode` = 11, `halt_req` pulsed high for 1 cycle → `cpu_en` = 0 from that cycle on; `stopped` = 1; stays stopped after `halt_req` = 0 until `sw_mode` = 00.
- `STEP_COUNTER_EN` defined, `CNT_W` = 4, FAST_RUN for 17 cycles → `step_count` wraps to 1; macro undefined → `step_count` = 0 throughout.
- `reset` driven low asynchronously in the middle of a FAST_RUN `cpu_en` cycle → `cpu_en`, `running`, `step_count` = 0 without waiting for a clock edge.
